// File: rtl/spi_master_ctrl.sv
// SPI master control unit: one {rw, addr, data} frame per accepted start, MSB first,
// with configurable width, SCLK divider, chip-select count and CPOL/CPHA per frame.
module spi_master_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned NUM_CS  = 2,
  localparam int unsigned CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              m_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              cpol,
  input  logic              cpha,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              spi_sclk,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int unsigned FRAME_W = ADDR_W + 1 + DATA_W;
  localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned DIV_W   = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [FRAME_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                rw_q, rw_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                sclk_q, sclk_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                mosi_q, mosi_d;

  logic                start_ok_c;
  logic                div_end_c;
  logic                edge_c;
  logic                leading_c;
  logic [FRAME_W-1:0]  frame_c;

  assign start_ok_c = start && (32'(cs_sel) < NUM_CS);
  assign div_end_c  = (div_q == DIV_W'(CLK_DIV - 1));
  assign leading_c  = (sclk_q == cpol_q);
  assign frame_c    = {rw, addr, (rw ? DATA_W'(0) : wdata)};

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rw_d    = rw_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    edge_c  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        div_d   = '0;
        bit_d   = '0;
        busy_d  = 1'b0;
        sclk_d  = cpol_q;
        cs_n_d  = '1;
        mosi_d  = 1'b0;
        if (start_ok_c) begin
          state_d = ST_SETUP;
          busy_d  = 1'b1;
          rw_d    = rw;
          cpol_d  = cpol;
          cpha_d  = cpha;
          tx_d    = frame_c;
          rx_d    = '0;
          sclk_d  = cpol;
          cs_n_d  = ~(NUM_CS'(1) << cs_sel);
          mosi_d  = cpha ? 1'b0 : frame_c[FRAME_W-1];
        end
      end
      ST_SETUP: begin
        div_d = div_q + DIV_W'(1);
        if (div_end_c) begin
          div_d   = '0;
          state_d = ST_SHIFT;
          edge_c  = 1'b1;
        end
      end
      ST_SHIFT: begin
        div_d = div_q + DIV_W'(1);
        if (div_end_c) begin
          div_d = '0;
          if (bit_q == BIT_W'(FRAME_W)) state_d = ST_HOLD;
          else                          edge_c  = 1'b1;
        end
      end
      ST_HOLD: begin
        div_d = div_q + DIV_W'(1);
        if (div_end_c) begin
          div_d   = '0;
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cs_n_d  = '1;
          mosi_d  = 1'b0;
          if (rw_q) rdata_d = rx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // SCLK edge: leading/trailing decides whether MOSI moves or MISO is sampled
    if (edge_c) begin
      sclk_d = ~sclk_q;
      if (leading_c) begin
        if (cpha_q) begin
          mosi_d = tx_q[FRAME_W-1];
          tx_d   = tx_q << 1;
        end else begin
          rx_d = DATA_W'({rx_q, spi_miso});
        end
      end else begin
        bit_d = bit_q + BIT_W'(1);
        if (cpha_q) begin
          rx_d = DATA_W'({rx_q, spi_miso});
        end else if (bit_q != BIT_W'(FRAME_W - 1)) begin
          tx_d   = tx_q << 1;
          mosi_d = tx_d[FRAME_W-1];
        end
      end
    end
  end

  always_ff @(posedge m_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rw_q    <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= '1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rw_q    <= rw_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench: three spi_master_ctrl configurations against an SPI slave model
// and a frame-level reference (expected MOSI word, busy length, edge counts, rdata).
module tb_spi_master_ctrl;

  logic        m_clk = 1'b0;
  logic        reset;
  logic        start_v;
  logic        rw_v, cpol_v, cpha_v;
  logic [1:0]  cs_sel_v;
  logic [14:0] addr_v;
  logic [15:0] wdata_v;
  logic        spi_miso = 1'b0;
  int          dut_sel;

  always #5 m_clk = ~m_clk;

  // A: defaults (N=16, CLK_DIV=4, NUM_CS=2)
  logic       a_busy, a_done, a_sclk, a_mosi;
  logic [7:0] a_rdata;
  logic [1:0] a_csn;
  logic       start_a;
  assign start_a = start_v && (dut_sel == 0);
  spi_master_ctrl u_a (
    .m_clk(m_clk), .reset(reset), .start(start_a), .rw(rw_v), .cs_sel(cs_sel_v[0:0]),
    .addr(addr_v[6:0]), .wdata(wdata_v[7:0]), .cpol(cpol_v), .cpha(cpha_v),
    .busy(a_busy), .done(a_done), .rdata(a_rdata), .spi_sclk(a_sclk),
    .spi_cs_n(a_csn), .spi_mosi(a_mosi), .spi_miso(spi_miso));

  // B: N=32, CLK_DIV=1, NUM_CS=4
  logic        b_busy, b_done, b_sclk, b_mosi;
  logic [15:0] b_rdata;
  logic [3:0]  b_csn;
  logic        start_b;
  assign start_b = start_v && (dut_sel == 1);
  spi_master_ctrl #(.DATA_W(16), .ADDR_W(15), .CLK_DIV(1), .NUM_CS(4)) u_b (
    .m_clk(m_clk), .reset(reset), .start(start_b), .rw(rw_v), .cs_sel(cs_sel_v),
    .addr(addr_v), .wdata(wdata_v), .cpol(cpol_v), .cpha(cpha_v),
    .busy(b_busy), .done(b_done), .rdata(b_rdata), .spi_sclk(b_sclk),
    .spi_cs_n(b_csn), .spi_mosi(b_mosi), .spi_miso(spi_miso));

  // C: N=8, CLK_DIV=2, NUM_CS=3 (cs_sel=3 is out of range)
  logic       c_busy, c_done, c_sclk, c_mosi;
  logic [3:0] c_rdata;
  logic [2:0] c_csn;
  logic       start_c;
  assign start_c = start_v && (dut_sel == 2);
  spi_master_ctrl #(.DATA_W(4), .ADDR_W(3), .CLK_DIV(2), .NUM_CS(3)) u_c (
    .m_clk(m_clk), .reset(reset), .start(start_c), .rw(rw_v), .cs_sel(cs_sel_v),
    .addr(addr_v[2:0]), .wdata(wdata_v[3:0]), .cpol(cpol_v), .cpha(cpha_v),
    .busy(c_busy), .done(c_done), .rdata(c_rdata), .spi_sclk(c_sclk),
    .spi_cs_n(c_csn), .spi_mosi(c_mosi), .spi_miso(spi_miso));

  logic        obs_busy, obs_done, obs_sclk, obs_mosi;
  logic [15:0] obs_rdata;
  logic [3:0]  obs_csn;
  always_comb begin
    obs_busy = a_busy; obs_done = a_done; obs_sclk = a_sclk; obs_mosi = a_mosi;
    obs_rdata = 16'(a_rdata); obs_csn = {2'b11, a_csn};
    if (dut_sel == 1) begin
      obs_busy = b_busy; obs_done = b_done; obs_sclk = b_sclk; obs_mosi = b_mosi;
      obs_rdata = b_rdata; obs_csn = b_csn;
    end else if (dut_sel == 2) begin
      obs_busy = c_busy; obs_done = c_done; obs_sclk = c_sclk; obs_mosi = c_mosi;
      obs_rdata = 16'(c_rdata); obs_csn = {1'b1, c_csn};
    end
  end

  // SPI slave model: counts edges, captures MOSI on its sampling edge, drives MISO
  logic [63:0] slv_word;
  int          slv_n;
  logic        slv_cpol, slv_cpha;
  int          slv_edges, slv_rises, slv_oidx;
  logic [63:0] slv_rx;
  logic        prev_act = 1'b0, prev_sclk = 1'b0;
  logic        cs_act, slv_lead;
  assign cs_act   = (obs_csn != 4'hF);
  assign slv_lead = (obs_sclk != slv_cpol);

  always @(negedge m_clk) begin
    if (cs_act && !prev_act) begin
      slv_edges <= 0; slv_rises <= 0; slv_rx <= '0; slv_oidx <= 0;
      if (!slv_cpha) begin
        spi_miso <= slv_word[slv_n-1];
        slv_oidx <= 1;
      end
    end else if (cs_act && obs_sclk != prev_sclk) begin
      slv_edges <= slv_edges + 1;
      if (obs_sclk) slv_rises <= slv_rises + 1;
      if (slv_lead != slv_cpha) begin
        slv_rx <= {slv_rx[62:0], obs_mosi};
      end else if (slv_oidx < slv_n) begin
        spi_miso <= slv_word[slv_n-1-slv_oidx];
        slv_oidx <= slv_oidx + 1;
      end
    end
    prev_act  <= cs_act;
    prev_sclk <= obs_sclk;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_rdata [3];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int frame_n(input int sel);
    return (sel == 0) ? 16 : (sel == 1) ? 32 : 8;
  endfunction
  function automatic int data_w(input int sel);
    return (sel == 0) ? 8 : (sel == 1) ? 16 : 4;
  endfunction
  function automatic int clk_div(input int sel);
    return (sel == 0) ? 4 : (sel == 1) ? 1 : 2;
  endfunction

  // Issue one frame and check it; returns at the negedge of its DONE cycle
  task automatic do_frame(input int sel, input bit rw_i, input int cs_i,
                          input logic [31:0] addr_i, input logic [31:0] wdata_i,
                          input bit cpol_i, input bit cpha_i, input logic [63:0] sword,
                          input bit poke);
    int n, dw, cd, aw, cnt, bad;
    logic [63:0] dmask, amask, nmask, frame;
    n = frame_n(sel); dw = data_w(sel); cd = clk_div(sel); aw = n - 1 - dw;
    dmask = (64'd1 << dw) - 64'd1;
    amask = (64'd1 << aw) - 64'd1;
    nmask = (64'd1 << n) - 64'd1;
    frame = (64'(rw_i) << (n - 1)) | ((64'(addr_i) & amask) << dw) |
            (rw_i ? 64'd0 : (64'(wdata_i) & dmask));
    dut_sel = sel;
    rw_v = rw_i; cs_sel_v = 2'(cs_i); addr_v = 15'(addr_i); wdata_v = 16'(wdata_i);
    cpol_v = cpol_i; cpha_v = cpha_i;
    slv_word = sword & nmask; slv_n = n; slv_cpol = cpol_i; slv_cpha = cpha_i;
    start_v = 1'b1;
    @(negedge m_clk);
    start_v = 1'b0;
    cnt = 0; bad = 0;
    while (obs_busy && cnt < 4000) begin
      cnt++;
      if (obs_csn != ~(4'b0001 << cs_i)) bad++;
      if (obs_done) bad++;
      if (poke && cnt == 10) begin
        start_v = 1'b1; cs_sel_v = 2'(cs_i ^ 1); cpol_v = ~cpol_i; cpha_v = ~cpha_i; rw_v = ~rw_i;
      end
      if (poke && cnt == 11) start_v = 1'b0;
      @(negedge m_clk);
    end
    check_eq("busy_len", 64'(cnt), 64'((2 * n + 2) * cd));
    check_eq("cs_during_frame", 64'(bad), 64'd0);
    check_eq("done_pulse", 64'(obs_done), 64'd1);
    check_eq("cs_at_done", 64'(obs_csn), 64'hF);
    check_eq("sclk_idle", 64'(obs_sclk), 64'(cpol_i));
    if (rw_i) exp_rdata[sel] = 16'(sword & dmask);
    check_eq("rdata", 64'(obs_rdata), 64'(exp_rdata[sel]));
    check_eq("mosi_frame", slv_rx & nmask, frame);
    check_eq("sclk_edges", 64'(slv_edges), 64'(2 * n));
    check_eq("sclk_rises", 64'(slv_rises), 64'(n));
  endtask

  // No frame activity for the selected DUT over the given cycles
  task automatic idle_check(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge m_clk);
      if (obs_busy || obs_done || obs_csn != 4'hF) bad++;
    end
    check_eq(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start_v = 1'b0; rw_v = 1'b0; cpol_v = 1'b0; cpha_v = 1'b0;
    cs_sel_v = '0; addr_v = '0; wdata_v = '0; dut_sel = 0;
    slv_word = '0; slv_n = 16; slv_cpol = 1'b0; slv_cpha = 1'b0;
    for (int i = 0; i < 3; i++) exp_rdata[i] = '0;
    repeat (3) @(negedge m_clk);
    for (int s = 0; s < 3; s++) begin
      dut_sel = s;
      #1;
      check_eq("rst_busy", 64'(obs_busy), 64'd0);
      check_eq("rst_done", 64'(obs_done), 64'd0);
      check_eq("rst_csn", 64'(obs_csn), 64'hF);
      check_eq("rst_sclk_mosi_rdata", {46'd0, obs_sclk, obs_mosi, obs_rdata}, 64'd0);
    end
    @(negedge m_clk);
    reset = 1'b0;
    @(negedge m_clk);

    // mode 0 write, with a start and mode change pulsed mid-frame
    do_frame(0, 1'b0, 1, 32'h2A, 32'hC3, 1'b0, 1'b0, 64'h1234, 1'b1);
    idle_check("ignored_start_busy", 20);
    // mode 3 read, then modes 1 and 2 with the same data pattern
    do_frame(0, 1'b1, 0, 32'h05, 32'h00, 1'b1, 1'b1, 64'h3CA5, 1'b0);
    idle_check("idle_after_m3", 3);
    do_frame(0, 1'b1, 1, 32'h11, 32'hFF, 1'b0, 1'b1, 64'h815A, 1'b0);
    idle_check("idle_after_m1", 3);
    do_frame(0, 1'b1, 0, 32'h6E, 32'h00, 1'b1, 1'b0, 64'h7E5A, 1'b0);
    idle_check("idle_after_m2", 3);

    // out-of-range chip select on the 3-CS instance
    dut_sel = 2; cs_sel_v = 2'd3; rw_v = 1'b0; start_v = 1'b1;
    @(negedge m_clk);
    start_v = 1'b0;
    idle_check("ignored_cs_oob", 30);
    do_frame(2, 1'b1, 2, 32'h5, 32'h0, 1'b0, 1'b0, 64'hC9, 1'b0);
    idle_check("idle_after_c", 3);

    // reset in the middle of a read's shift phase
    dut_sel = 0; rw_v = 1'b1; cs_sel_v = 2'd1; cpol_v = 1'b1; cpha_v = 1'b0;
    slv_word = 64'hFFFF; slv_n = 16; slv_cpol = 1'b1; slv_cpha = 1'b0;
    start_v = 1'b1;
    @(negedge m_clk);
    start_v = 1'b0;
    repeat (40) @(negedge m_clk);
    reset = 1'b1;
    @(negedge m_clk);
    reset = 1'b0;
    check_eq("midrst_csn", 64'(obs_csn), 64'hF);
    check_eq("midrst_sclk", 64'(obs_sclk), 64'd0);
    check_eq("midrst_busy_done", {62'd0, obs_busy, obs_done}, 64'd0);
    check_eq("midrst_rdata", 64'(obs_rdata), 64'd0);
    for (int i = 0; i < 3; i++) exp_rdata[i] = '0;
    idle_check("midrst_no_done", 10);
    do_frame(0, 1'b1, 0, 32'h33, 32'h0, 1'b0, 1'b0, 64'h9C6B, 1'b0);
    idle_check("idle_after_rst_frame", 3);

    // back-to-back starts in the DONE cycle on the wide instance
    for (int f = 0; f < 4; f++)
      do_frame(1, f[0], f, 32'(16'h1357 * (f + 1)), 32'(16'hBEEF + f), f[1], f[0],
               {$urandom, $urandom}, 1'b0);
    idle_check("idle_after_b2b", 3);

    // randomized frames across all instances
    for (int k = 0; k < 14; k++) begin
      int sel, ncs;
      bit b2b;
      sel = int'($urandom_range(0, 2));
      ncs = (sel == 0) ? 2 : (sel == 1) ? 4 : 3;
      b2b = 1'($urandom_range(0, 1));
      do_frame(sel, 1'($urandom), int'($urandom_range(0, ncs - 1)), $urandom, $urandom,
               1'($urandom), 1'($urandom), {$urandom, $urandom}, 1'($urandom));
      if (!b2b) idle_check("idle_random", 3);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
